// File: rtl/pea_pkg.sv
// pea_pkg: shared PEA sizing constants for the output staging stage
package pea_pkg;
    localparam int N_OUT_PEA      = 4;
    localparam int M              = 6;
    localparam int LOG_M          = 3;
    localparam int DATA_W         = 32;
    localparam int OUT_FIFO_DEPTH = 4;
endpackage

// File: rtl/pea_out_fifo.sv
// pea_out_fifo: single-channel synchronous FIFO with registered head, flush and overflow pulse
module pea_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o,
    output logic              ovf_o
);
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DATA_W-1:0]            last_q;
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic                         pop_ok, push_ok;

    assign empty_o = count_o == '0;
    assign full_o  = count_o == CW'(DEPTH);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign ovf_o   = push_i && !push_ok && !flush_i;
    assign head_o  = empty_o ? last_q : mem[rd_ptr];

    // Storage, pointers and occupancy; last_q keeps the most recent head so data holds when empty
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem     <= '0;
            last_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (!empty_o) last_q <= mem[rd_ptr];
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_o <= '0;
            end else begin
                if (push_ok) begin
                    mem[wr_ptr] <= push_data_i;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
                count_o <= count_o + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end
endmodule

// File: rtl/pea_out_stream.sv
// pea_out_stream: PEA output selector mux, per-channel FIFOs and stall generation; PEA_OUT_OVF_EN adds sticky ovf_o
module pea_out_stream
    import pea_pkg::*;
#(
    parameter int N_OUT  = N_OUT_PEA,
    parameter int M      = pea_pkg::M,
    parameter int LOG_M  = pea_pkg::LOG_M,
    parameter int DATA_W = pea_pkg::DATA_W,
    parameter int DEPTH  = OUT_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [N_OUT-1:0][LOG_M-1:0]  sel_output_i,
    input  logic [N_OUT-1:0]             out_en_i,
    input  logic                         flush_i,
    input  logic [M-1:0][DATA_W-1:0]     pe_data_i,
    input  logic [M-1:0]                 pe_valid_i,
    output logic                         stall_o,
    output logic [N_OUT-1:0][DATA_W-1:0] out_data_o,
    output logic [N_OUT-1:0]             out_valid_o,
    input  logic [N_OUT-1:0]             out_ready_i
`ifdef PEA_OUT_OVF_EN
    ,
    output logic [N_OUT-1:0]             ovf_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_OUT-1:0]         push, full, empty;
    logic [N_OUT-1:0][CW-1:0] count_unused;
`ifdef PEA_OUT_OVF_EN
    logic [N_OUT-1:0]         ovf_pulse;
`else
    logic [N_OUT-1:0]         ovf_unused;
`endif

    assign stall_o     = |(out_en_i & full);
    assign out_valid_o = ~empty;

    for (genvar c = 0; c < N_OUT; c++) begin : g_ch
        logic sel_ok;
        assign sel_ok  = {1'b0, sel_output_i[c]} < (LOG_M + 1)'(M);
        assign push[c] = out_en_i[c] && sel_ok && pe_valid_i[sel_output_i[c]];

        pea_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .flush_i     (flush_i),
            .push_i      (push[c]),
            .push_data_i (pe_data_i[sel_output_i[c]]),
            .pop_i       (out_ready_i[c]),
            .head_o      (out_data_o[c]),
            .full_o      (full[c]),
            .empty_o     (empty[c]),
            .count_o     (count_unused[c]),
`ifdef PEA_OUT_OVF_EN
            .ovf_o       (ovf_pulse[c])
`else
            .ovf_o       (ovf_unused[c])
`endif
        );
    end

`ifdef PEA_OUT_OVF_EN
    // Sticky per-channel overflow, cleared only by reset or flush
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) ovf_o <= '0;
        else ovf_o <= ovf_o | ovf_pulse;
    end
`endif
endmodule

// File: doc/pea_out_stream.md
# pea_out_stream

Output staging stage of the PEA, directly downstream of the output-selector configuration block. Each PEA output channel uses its configured selector to pick one of the M PE results. The chosen word is pushed into a small per-channel FIFO. The FIFO contents are then presented on valid/ready stream ports toward the output streaming units. A single stall line throttles the PEA whenever an enabled channel cannot accept data.

## Interface

Parameters:
- N_OUT: default N_OUT_PEA (pea_pkg). Number of output channels.
- M: default M (pea_pkg). Number of PE result candidates.
- LOG_M: default LOG_M (pea_pkg). Selector width.
- DATA_W: default 32. Word width.
- DEPTH: default 4. FIFO entries per channel; power of two, ≥2.

Ports (clock and reset first):
- clk_i, input, 1: clock.
- rst_n_i, input, 1: synchronous active-low reset.
- sel_output_i, input, N_OUT×LOG_M: per-channel PE selector; held stable during operation.
- out_en_i, input, N_OUT: channel enable mask.
- flush_i, input, 1: synchronous clear of all FIFOs.
- pe_data_i, input, M×DATA_W: PE results.
- pe_valid_i, input, M: per-PE result valid.
- stall_o, output, 1: PEA must not assert new pe_valid_i while high.
- out_data_o, output, N_OUT×DATA_W: stream data (FIFO head).
- out_valid_o, output, N_OUT: stream valid.
- out_ready_i, input, N_OUT: stream ready.
- ovf_o, output, N_OUT: sticky overflow flags. Present only with PEA_OUT_OVF_EN.

## Operation

- Channel c push condition: out_en_i[c] && pe_valid_i[sel_output_i[c]]. The pushed word is pe_data_i[sel_output_i[c]].
- Selector values ≥ M never push and are not an error.
- Pop condition: out_valid_o[c] && out_ready_i[c].
- Accept rule: a push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the push is dropped (and flagged, see Configuration).
- Occupancy arithmetic:
  - Count width is clog2(DEPTH)+1.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - Empty: count = 0. Full: count = DEPTH.
- stall_o = OR over c of (out_en_i[c] && full[c]). It is combinational from registered counts and has no combinational path from pe_valid_i.
- out_valid_o[c] = count[c] != 0. out_data_o[c] is the FIFO head when valid; otherwise it holds its last value.
- Disabled channels:
  - Deasserting out_en_i[c] stops new pushes only.
  - Existing entries continue to drain.
  - A disabled channel never contributes to stall_o.
- Flush: flush_i clears all pointers and counts in the next cycle and clears ovf_o. A push or pop in the same cycle as flush_i is discarded.
- Reset: the same effect as flush. All outputs read 0 after reset, including out_data_o, which is built from registered storage reset to 0.

## Timing

- Write latency: a word pushed in cycle t appears on out_valid_o/out_data_o in cycle t+1. There is no fall-through.
- Back-to-back throughput is one word per channel per cycle, with ready held high.
- stall_o rises in the cycle after the push that fills the FIFO.
- stall_o falls in the cycle after the first pop from a full FIFO, unless a simultaneous push refilled it.
- A reset or flush asserted mid-stream takes effect at the next edge. Data in flight is lost and no partial state remains.

## Configuration

PEA_OUT_OVF_EN:
- Defined:
  - ovf_o[c] sets on any dropped push for channel c.
  - It stays set until reset or flush.
- Not defined:
  - ovf_o and its registers are absent.
  - Dropped pushes are silently discarded.
- Datapath behaviour is otherwise identical.

## Structure

- pea_pkg holds N_OUT_PEA, M, LOG_M and DATA_W, plus the OUT_FIFO_DEPTH constant used as the DEPTH default.
- One sub-module, pea_out_fifo: single-channel synchronous FIFO with push, pop, flush, full, empty, count and an overflow pulse.
  - It is instantiated N_OUT times in a generate loop.
  - The selector mux and stall OR live in the top level.

## Test plan

- Reset, then idle: all out_valid_o = 0, stall_o = 0, out_data_o = 0.
- Channel 0 with sel=2; push 0xA5A5_0001 in cycle 5 with out_ready_i high -> out_valid_o[0] = 1 with that data in cycle 6, and empty in cycle 7.
- DEPTH = 4, out_ready_i = 0, five pushes of 1..5 -> stall_o high after the 4th push. With PEA_OUT_OVF_EN, the 5th push is dropped and ovf_o[0] = 1. Drain order is 1, 2, 3, 4.
- Full FIFO with a simultaneous push of 9 and pop -> count stays 4, stall_o stays 1, and 9 exits last.
- Two channels with the same selector=1 -> both receive an identical word stream. Disable channel 1 while it is full -> stall_o drops and channel 1 still drains.
- flush_i asserted while FIFOs hold 3 entries -> next cycle all out_valid_o = 0, ovf_o = 0, stall_o = 0.
